// File: rtl/id_ex_stage_if.sv
// ID/EX bundle: decode-side operands/control in (i_*), EX-side registered view out (o_*).
// master is the upstream ID/hazard-control side; slave is the pipeline register itself.
interface id_ex_stage_if #(
  parameter int LEN      = 32,
  parameter int NB_ADDR  = 5,
  parameter int NB_ALUOP = 2
);
  logic                i_valid;
  logic [LEN-1:0]      i_read_data_1;
  logic [LEN-1:0]      i_read_data_2;
  logic [NB_ADDR-1:0]  i_rs;
  logic [NB_ADDR-1:0]  i_rt;
  logic [NB_ADDR-1:0]  i_rd;
  logic [LEN-1:0]      i_imm;
  logic [LEN-1:0]      i_pc4;
  logic                i_RegWrite;
  logic                i_MemRead;
  logic                i_MemWrite;
  logic                i_MemtoReg;
  logic                i_ALUSrc;
  logic                i_RegDst;
  logic [NB_ALUOP-1:0] i_ALUOp;
  logic                i_wb_RegWrite;
  logic [NB_ADDR-1:0]  i_wb_register;
  logic [LEN-1:0]      i_wb_data;
  logic                i_flush;
  logic                i_hold;

  logic                o_stall;
  logic                o_valid;
  logic [LEN-1:0]      o_read_data_1;
  logic [LEN-1:0]      o_read_data_2;
  logic [LEN-1:0]      o_imm;
  logic [LEN-1:0]      o_pc4;
  logic [NB_ADDR-1:0]  o_rs;
  logic [NB_ADDR-1:0]  o_rt;
  logic [NB_ADDR-1:0]  o_rd;
  logic                o_RegWrite;
  logic                o_MemRead;
  logic                o_MemWrite;
  logic                o_MemtoReg;
  logic                o_ALUSrc;
  logic                o_RegDst;
  logic [NB_ALUOP-1:0] o_ALUOp;

  modport master (
    output i_valid, i_read_data_1, i_read_data_2, i_rs, i_rt, i_rd, i_imm, i_pc4,
           i_RegWrite, i_MemRead, i_MemWrite, i_MemtoReg, i_ALUSrc, i_RegDst, i_ALUOp,
           i_wb_RegWrite, i_wb_register, i_wb_data, i_flush, i_hold,
    input  o_stall, o_valid, o_read_data_1, o_read_data_2, o_imm, o_pc4, o_rs, o_rt, o_rd,
           o_RegWrite, o_MemRead, o_MemWrite, o_MemtoReg, o_ALUSrc, o_RegDst, o_ALUOp
  );

  modport slave (
    input  i_valid, i_read_data_1, i_read_data_2, i_rs, i_rt, i_rd, i_imm, i_pc4,
           i_RegWrite, i_MemRead, i_MemWrite, i_MemtoReg, i_ALUSrc, i_RegDst, i_ALUOp,
           i_wb_RegWrite, i_wb_register, i_wb_data, i_flush, i_hold,
    output o_stall, o_valid, o_read_data_1, o_read_data_2, o_imm, o_pc4, o_rs, o_rt, o_rd,
           o_RegWrite, o_MemRead, o_MemWrite, o_MemtoReg, o_ALUSrc, o_RegDst, o_ALUOp
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble and WB bypass; 1-cycle latency.
// Backpressure: i_hold freezes the stage; o_stall (combinational) holds PC/IF-ID on hold or load-use.
module id_ex_stage #(
  parameter int LEN      = 32,
  parameter int NB_ADDR  = 5,
  parameter int NB_ALUOP = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic                valid;
    logic [LEN-1:0]      rd1;
    logic [LEN-1:0]      rd2;
    logic [LEN-1:0]      imm;
    logic [LEN-1:0]      pc4;
    logic [NB_ADDR-1:0]  rs;
    logic [NB_ADDR-1:0]  rt;
    logic [NB_ADDR-1:0]  rd;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                alu_src;
    logic                reg_dst;
    logic [NB_ALUOP-1:0] alu_op;
  } ex_t;

  ex_t  ex_q;
  ex_t  ex_d;
  logic hz;
  logic wb_hit_1;
  logic wb_hit_2;
  logic bubble;

  // A load in EX whose target feeds the ID instruction cannot forward in time.
  assign hz = ex_q.valid & ex_q.mem_read & bus.i_valid & (ex_q.rt != '0) &
              ((ex_q.rt == bus.i_rs) | (ex_q.rt == bus.i_rt));

  assign bus.o_stall = i_rst & (hz | bus.i_hold);
  assign bubble      = bus.i_flush | (~bus.i_hold & hz);

  assign wb_hit_1 = bus.i_wb_RegWrite & (bus.i_wb_register != '0) & (bus.i_wb_register == bus.i_rs);
  assign wb_hit_2 = bus.i_wb_RegWrite & (bus.i_wb_register != '0) & (bus.i_wb_register == bus.i_rt);

  always_comb begin
    ex_d            = '0;
    ex_d.valid      = bus.i_valid;
    ex_d.rd1        = wb_hit_1 ? bus.i_wb_data : bus.i_read_data_1;
    ex_d.rd2        = wb_hit_2 ? bus.i_wb_data : bus.i_read_data_2;
    ex_d.imm        = bus.i_imm;
    ex_d.pc4        = bus.i_pc4;
    ex_d.rs         = bus.i_rs;
    ex_d.rt         = bus.i_rt;
    ex_d.rd         = bus.i_rd;
    // Control of a non-instruction slot must never write state downstream.
    ex_d.reg_write  = bus.i_valid & bus.i_RegWrite;
    ex_d.mem_read   = bus.i_valid & bus.i_MemRead;
    ex_d.mem_write  = bus.i_valid & bus.i_MemWrite;
    ex_d.mem_to_reg = bus.i_valid & bus.i_MemtoReg;
    ex_d.alu_src    = bus.i_valid & bus.i_ALUSrc;
    ex_d.reg_dst    = bus.i_valid & bus.i_RegDst;
    ex_d.alu_op     = bus.i_valid ? bus.i_ALUOp : {NB_ALUOP{1'b0}};
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ex_q <= '0;
    end else if (bubble) begin
      ex_q <= '0;
    end else if (!bus.i_hold) begin
      ex_q <= ex_d;
    end
  end

  assign bus.o_valid       = ex_q.valid;
  assign bus.o_read_data_1 = ex_q.rd1;
  assign bus.o_read_data_2 = ex_q.rd2;
  assign bus.o_imm         = ex_q.imm;
  assign bus.o_pc4         = ex_q.pc4;
  assign bus.o_rs          = ex_q.rs;
  assign bus.o_rt          = ex_q.rt;
  assign bus.o_rd          = ex_q.rd;
  assign bus.o_RegWrite    = ex_q.reg_write;
  assign bus.o_MemRead     = ex_q.mem_read;
  assign bus.o_MemWrite    = ex_q.mem_write;
  assign bus.o_MemtoReg    = ex_q.mem_to_reg;
  assign bus.o_ALUSrc      = ex_q.alu_src;
  assign bus.o_RegDst      = ex_q.reg_dst;
  assign bus.o_ALUOp       = ex_q.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed scenarios then randomized traffic against a reference model.
module tb_id_ex_stage;

  logic i_clk;
  logic i_rst;

  id_ex_stage_if #(.LEN(32), .NB_ADDR(5), .NB_ALUOP(2)) bus ();

  id_ex_stage #(.LEN(32), .NB_ADDR(5), .NB_ALUOP(2)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ctl = {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst}
  typedef struct packed {
    logic        valid;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  ctl;
    logic [1:0]  aluop;
  } ex_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  ctl;
    logic [1:0]  aluop;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        flush;
    logic        hold;
  } id_t;

  typedef struct packed {
    logic stall;
    ex_t  ex;
  } exp_t;

  exp_t exp_q[$];
  ex_t  model;
  int   total = 0;
  int   bad   = 0;

  // ---------------- reference model ----------------
  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf, input id_t v);
    if (v.wb_we && r != 5'd0 && r == v.wb_reg) return v.wb_data;
    return rf;
  endfunction

  function automatic logic load_use(input ex_t s, input id_t v);
    return s.valid && s.ctl[4] && v.valid && s.rt != 5'd0 && (s.rt == v.rs || s.rt == v.rt);
  endfunction

  function automatic ex_t next_ex(input ex_t s, input id_t v);
    ex_t n;
    if (v.flush) return '0;
    if (v.hold) return s;
    if (load_use(s, v)) return '0;
    n.valid = v.valid;
    n.rd1   = operand(v.rs, v.rd1, v);
    n.rd2   = operand(v.rt, v.rd2, v);
    n.imm   = v.imm;
    n.pc4   = v.pc4;
    n.rs    = v.rs;
    n.rt    = v.rt;
    n.rd    = v.rd;
    n.ctl   = v.valid ? v.ctl : 6'd0;
    n.aluop = v.valid ? v.aluop : 2'd0;
    return n;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic id_t instr(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                                input logic [5:0] ctl, input logic [1:0] aluop);
    id_t v = '0;
    v.valid = valid; v.rs = rs; v.rt = rt; v.rd = rd;
    v.rd1 = d1; v.rd2 = d2; v.ctl = ctl; v.aluop = aluop;
    v.imm = $urandom; v.pc4 = $urandom;
    return v;
  endfunction

  task automatic apply(input id_t v);
    bus.i_valid       = v.valid;
    bus.i_read_data_1 = v.rd1;
    bus.i_read_data_2 = v.rd2;
    bus.i_imm         = v.imm;
    bus.i_pc4         = v.pc4;
    bus.i_rs          = v.rs;
    bus.i_rt          = v.rt;
    bus.i_rd          = v.rd;
    {bus.i_RegWrite, bus.i_MemRead, bus.i_MemWrite,
     bus.i_MemtoReg, bus.i_ALUSrc, bus.i_RegDst} = v.ctl;
    bus.i_ALUOp       = v.aluop;
    bus.i_wb_RegWrite = v.wb_we;
    bus.i_wb_register = v.wb_reg;
    bus.i_wb_data     = v.wb_data;
    bus.i_flush       = v.flush;
    bus.i_hold        = v.hold;
  endtask

  // Called 1 time unit after a posedge: present inputs, record what this cycle must show, advance.
  task automatic drive(input id_t v);
    exp_t e;
    apply(v);
    e.stall = i_rst && (load_use(model, v) || v.hold);
    e.ex    = model;
    exp_q.push_back(e);
    @(posedge i_clk);
    if (i_rst) model = next_ex(model, v);
    else       model = '0;
    #1;
  endtask

  // Asynchronous reset landing mid-cycle, released after one edge.
  task automatic mid_reset(input id_t v);
    exp_t e;
    apply(v);
    #1;
    i_rst = 1'b0;
    model = '0;
    e.stall = 1'b0;
    e.ex    = '0;
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
  endtask

  function automatic ex_t sample();
    ex_t a;
    a.valid = bus.o_valid;
    a.rd1   = bus.o_read_data_1;
    a.rd2   = bus.o_read_data_2;
    a.imm   = bus.o_imm;
    a.pc4   = bus.o_pc4;
    a.rs    = bus.o_rs;
    a.rt    = bus.o_rt;
    a.rd    = bus.o_rd;
    a.ctl   = {bus.o_RegWrite, bus.o_MemRead, bus.o_MemWrite, bus.o_MemtoReg, bus.o_ALUSrc, bus.o_RegDst};
    a.aluop = bus.o_ALUOp;
    return a;
  endfunction

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    ex_t  a;
    forever begin
      @(negedge i_clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = sample();
        check("stall",    {159'd0, bus.o_stall}, {159'd0, e.stall});
        check("valid",    {159'd0, a.valid},     {159'd0, e.ex.valid});
        check("operands", {96'd0, a.rd1, a.rd2}, {96'd0, e.ex.rd1, e.ex.rd2});
        check("ctl",      {152'd0, a.ctl, a.aluop}, {152'd0, e.ex.ctl, e.ex.aluop});
        check("record",   {8'd0, a},             {8'd0, e.ex});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    id_t nop, v, lw, use_i, cur;
    nop   = '0;
    model = '0;
    i_rst = 1'b0;
    apply(nop);
    @(posedge i_clk);
    #1;

    // Reset held with hold asserted: stall must stay low.
    v = nop; v.hold = 1'b1;
    drive(v);
    drive(nop);
    i_rst = 1'b1;

    // Plain load.
    drive(instr(1'b1, 5'd3, 5'd4, 5'd9, 32'h11, 32'h22, 6'b100000, 2'd2));
    drive(nop);

    // Load-use on rs: one bubble then reload.
    lw    = instr(1'b1, 5'd2, 5'd5, 5'd0, 32'h100, 32'h0, 6'b110100, 2'd0);
    use_i = instr(1'b1, 5'd5, 5'd6, 5'd7, 32'h33, 32'h44, 6'b100000, 2'd2);
    drive(lw);
    drive(use_i);
    drive(use_i);
    drive(nop);

    // Load targeting r0 never hazards.
    lw.rt = 5'd0;
    drive(lw);
    drive(instr(1'b1, 5'd1, 5'd0, 5'd8, 32'h55, 32'h66, 6'b100010, 2'd1));
    drive(nop);

    // WB bypass, then the same with r0 as destination.
    v = instr(1'b1, 5'd1, 5'd7, 5'd3, 32'h77, 32'h1, 6'b100001, 2'd2);
    v.wb_we = 1'b1; v.wb_reg = 5'd7; v.wb_data = 32'hDEADBEEF;
    drive(v);
    v.wb_reg = 5'd0;
    drive(v);
    drive(nop);

    // Flush beats hold.
    drive(instr(1'b1, 5'd4, 5'd5, 5'd6, 32'h88, 32'h99, 6'b101000, 2'd3));
    v = instr(1'b1, 5'd1, 5'd2, 5'd3, 32'hAA, 32'hBB, 6'b100000, 2'd2);
    v.flush = 1'b1; v.hold = 1'b1;
    drive(v);
    drive(nop);

    // Hold alone for three cycles.
    drive(instr(1'b1, 5'd4, 5'd5, 5'd6, 32'hCC, 32'hDD, 6'b100011, 2'd1));
    v = instr(1'b1, 5'd9, 5'd10, 5'd11, 32'hEE, 32'hFF, 6'b010000, 2'd0);
    v.hold = 1'b1;
    drive(v);
    drive(v);
    drive(v);
    drive(nop);

    // Reset arriving while a load-use stall is pending.
    lw.rt = 5'd5;
    drive(lw);
    mid_reset(use_i);
    drive(use_i);
    drive(nop);

    // Randomized traffic; upstream honours o_stall by re-presenting the same instruction.
    cur = nop;
    for (int n = 0; n < 1500; n++) begin
      if (!(load_use(model, cur) || cur.hold)) begin
        cur = instr($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), $urandom, $urandom, 6'($urandom), 2'($urandom));
      end
      cur.wb_we   = $urandom_range(0, 1) != 0;
      cur.wb_reg  = 5'($urandom_range(0, 7));
      cur.wb_data = $urandom;
      cur.flush   = $urandom_range(0, 15) == 0;
      cur.hold    = $urandom_range(0, 7) == 0;
      drive(cur);
    end
    drive(nop);

    repeat (3) @(negedge i_clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core. It sits directly downstream of the register file and the decoder, and feeds the EX stage.
- Latches the operands, register specifiers, immediate, PC+4 and control bits.
- Detects load-use hazards and inserts a one-cycle bubble.
- Bypasses same-cycle write-back data onto the operands.
- Supports flush (taken branch/jump) and hold (downstream stall).

Parameters:
- LEN, 32, datapath width (operands, immediate, PC)
- NB_ADDR, 5, register specifier width
- NB_ALUOP, 2, ALUOp field width

Ports:
- i_clk  in  1  clock; all state updates on posedge
- i_rst  in  1  asynchronous, active-low reset
- i_valid  in  1  ID holds a real instruction this cycle
- i_read_data_1  in  LEN  register file read port 1 data (rs)
- i_read_data_2  in  LEN  register file read port 2 data (rt)
- i_rs  in  NB_ADDR  rs specifier
- i_rt  in  NB_ADDR  rt specifier
- i_rd  in  NB_ADDR  rd specifier
- i_imm  in  LEN  sign-extended immediate
- i_pc4  in  LEN  PC+4 of the ID instruction
- i_RegWrite, i_MemRead, i_MemWrite, i_MemtoReg, i_ALUSrc, i_RegDst  in  1 each  decoder control bits
- i_ALUOp  in  NB_ALUOP  ALU operation class
- i_wb_RegWrite  in  1  WB stage writes the register file this cycle
- i_wb_register  in  NB_ADDR  WB destination register
- i_wb_data  in  LEN  WB write data
- i_flush  in  1  squash the instruction entering EX
- i_hold  in  1  EX/MEM stalled; freeze this stage
- o_stall  out  1  PC/IF-ID must hold this cycle (combinational)
- o_valid  out  1  registered; EX holds a real instruction
- o_read_data_1, o_read_data_2, o_imm, o_pc4  out  LEN  registered operands
- o_rs, o_rt, o_rd  out  NB_ADDR  registered specifiers
- o_RegWrite, o_MemRead, o_MemWrite, o_MemtoReg, o_ALUSrc, o_RegDst  out  1  registered control
- o_ALUOp  out  NB_ALUOP  registered ALUOp

Behaviour:
- Reset (i_rst=0, asynchronous): every registered output goes to 0 immediately, including o_valid. o_stall evaluates to 0 while in reset.
- Load-use detect (combinational): hz = o_valid & o_MemRead & i_valid & (o_rt != 0) & ((o_rt == i_rs) | (o_rt == i_rt)).
- o_stall = hz | i_hold.
- Posedge update priority, highest first:
  1. i_flush: bubble. o_valid and all control outputs go to 0; data and specifier outputs go to 0.
  2. i_hold: all outputs keep their value. i_flush still overrides i_hold.
  3. hz: bubble, identical to flush. Upstream holds the same instruction, which reloads next cycle; hz is then 0 because o_MemRead=0. Stall length is exactly 1 cycle.
  4. Otherwise: load all inputs. o_valid <= i_valid. If i_valid=0, control outputs load 0 regardless of the i_* control values.
- WB bypass, applied on load only:
  - o_read_data_1 <= (i_wb_RegWrite & i_wb_register != 0 & i_wb_register == i_rs) ? i_wb_data : i_read_data_1.
  - o_read_data_2 uses the same rule with i_rt.
- Register 0 is never bypassed and never causes a hazard.
- Latency: 1 cycle from ID to EX-visible outputs.
- No internal arithmetic. Widths pass through unchanged.
- Reset asserted mid-stall clears the bubble state. After release, the first edge performs a normal load.

Test Plan:
- Reset: assert i_rst=0 mid-cycle with o_valid=1 -> all outputs 0 immediately, before the next edge; o_stall=0.
- Plain load: i_valid=1, rs=3, rt=4, data 0x11/0x22, i_RegWrite=1, i_ALUOp=2 -> next edge o_read_data_1=0x11, o_read_data_2=0x22, o_RegWrite=1, o_ALUOp=2, o_valid=1.
- Load-use: EX holds lw with o_rt=5, ID instr with i_rs=5 -> o_stall=1 for exactly 1 cycle. Next edge o_valid=0 and all control 0. The edge after that loads the ID instruction, and o_stall=0.
- Load-use on r0: EX lw with o_rt=0, ID i_rt=0 -> o_stall=0, normal load.
- WB bypass: i_wb_RegWrite=1, i_wb_register=7, i_wb_data=0xDEADBEEF, i_rt=7, i_read_data_2=0x1 -> o_read_data_2=0xDEADBEEF. With i_wb_register=0 -> 0x1.
- Flush vs hold: i_flush=1 and i_hold=1 together -> bubble (o_valid=0). i_hold=1 alone for 3 cycles -> outputs unchanged and o_stall=1 throughout.
